test_stim_gen: RTL and testbench

Parametrised, sequential successor to the board test-output block. It drives the buzzer, LED and 7-segment point vectors, and it also runs a programmable fill sequencer. The sequencer writes DEPTH words of a selectable data pattern into the on-board RAM port (pdata/addr/wea). Writes are paced by a bit of the clock-divider bus. The block sits between the switch/divider sources and the RAM/display glue of the IP2SOC test top.

---
 rtl/test_stim_gen.sv | 173 +++++++++++++++++
 tb/tb_test_stim_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_stim_gen.sv
// Board test stimulus: registered buzzer/LED/point vectors plus a paced RAM fill sequencer.
// Optional macro TSG_LFSR_EN turns pattern mode 11 into a Fibonacci LFSR (default: constant all-ones).
module test_stim_gen #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 16,
    parameter int DIV_W    = 32,
    parameter int STEP_BIT = 24,
    parameter int BUZ_BIT  = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       sw,
    input  logic [DIV_W-1:0]  div,
    input  logic [7:0]        blink,
    input  logic              start,
    output logic              buzzer,
    output logic [63:0]       points,
    output logic [63:0]       les,
    output logic [DATA_W-1:0] pdata,
    output logic [ADDR_W-1:0] addr,
    output logic              wea,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int EXT_W = (DATA_W > 32) ? DATA_W : 32;
    localparam int C8_W  = (CNT_W > 8) ? CNT_W : 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    function automatic logic [DATA_W-1:0] seed_of(input logic [1:0] mode, input logic [15:0] s);
        logic [EXT_W-1:0]  dup;
        logic [DATA_W-1:0] res;
        dup = EXT_W'({s, s});
        case (mode)
            2'b00:   res = dup[DATA_W-1:0];
            2'b01:   res = DATA_W'(s);
            2'b10:   res = DATA_W'(1);
            default: begin
`ifdef TSG_LFSR_EN
                res = dup[DATA_W-1:0] | DATA_W'(1);
`else
                res = '1;
`endif
            end
        endcase
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] next_pd(input logic [1:0] mode, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] res;
        case (mode)
            2'b00:   res = d;
            2'b01:   res = d + DATA_W'(1);
            2'b10:   res = {d[DATA_W-2:0], d[DATA_W-1]};
            default: begin
`ifdef TSG_LFSR_EN
                res = {d[DATA_W-2:0], d[DATA_W-1] ^ d[DATA_W-11] ^ d[1] ^ d[0]};
`else
                res = d;
`endif
            end
        endcase
        return res;
    endfunction

    state_t            state_q, state_d;
    logic              start_q, div_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic [1:0]        mode_q, mode_d;
    logic              wea_q, wea_d;
    logic              buzzer_q, buzzer_d;
    logic [63:0]       les_q, les_d, points_q, points_d;

    logic              start_edge, tick, load;
    logic [ADDR_W-1:0] base;
    logic [C8_W-1:0]   cnt_ext;
    logic [EXT_W-1:0]  pd_ext;

    assign start_edge = start & ~start_q;
    assign tick       = div[STEP_BIT] & ~div_q;
    assign base       = ADDR_W'({sw[3], 4'b0000});
    assign load       = start_edge & sw[7] & (state_q != S_FILL);
    assign cnt_ext    = C8_W'(cnt_q);
    assign pd_ext     = EXT_W'(pdata_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (load) state_d = S_FILL;
            S_FILL: begin
                if (!sw[7])                      state_d = S_IDLE;
                else if (wea_q && cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (load)        state_d = S_FILL;
                else if (!sw[7]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        pdata_d = pdata_q;
        mode_d  = mode_q;
        if (load) begin
            cnt_d   = '0;
            addr_d  = base;
            pdata_d = seed_of(sw[6:5], sw);
            mode_d  = sw[6:5];
        end else if (state_q == S_FILL && sw[7] && wea_q) begin
            // The final write bumps the count but leaves address and data on the last word.
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q != LAST) begin
                addr_d  = addr_q + ADDR_W'(1);
                pdata_d = next_pd(mode_q, pdata_q);
            end
        end
        // Abort (sw[7] low) wins over a coincident tick.
        wea_d    = (state_q == S_FILL) & sw[7] & tick;
        buzzer_d = sw[8] & div[BUZ_BIT] & (state_q == S_FILL);
        les_d    = {blink, blink, 8'h00, cnt_ext[7:0], 32'h0};
        points_d = {pd_ext[31:0], div[31:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            pdata_q  <= '0;
            mode_q   <= 2'b00;
            wea_q    <= 1'b0;
            buzzer_q <= 1'b0;
            les_q    <= '0;
            points_q <= '0;
        end else begin
            start_q  <= start;
            div_q    <= div[STEP_BIT];
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            pdata_q  <= pdata_d;
            mode_q   <= mode_d;
            wea_q    <= wea_d;
            buzzer_q <= buzzer_d;
            les_q    <= les_d;
            points_q <= points_d;
        end
    end

    assign buzzer = buzzer_q;
    assign points = points_q;
    assign les    = les_q;
    assign pdata  = pdata_q;
    assign addr   = addr_q;
    assign wea    = wea_q;
    assign busy   = (state_q == S_FILL);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_test_stim_gen.sv
// Directed bench for test_stim_gen: three instances (default, 5-bit address wrap, 40-word run).
module tb_test_stim_gen;

    localparam int DEP [3] = '{16, 20, 40};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = 16'h0;
    logic [31:0] div = 32'h0;
    logic [7:0]  blink = 8'h0;
    logic        start = 1'b0;

    logic        buz_o  [3];
    logic [63:0] pts_o  [3];
    logic [63:0] les_o  [3];
    logic [31:0] pd_o   [3];
    logic        wea_o  [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic [9:0]  ad0, ad2;
    logic [4:0]  ad1;

    int n_chk = 0;
    int n_fail = 0;
    int n_wr [3];
    logic [31:0] pdlog [3][40];
    logic [9:0]  last_ad [3];

    always #5 clk = ~clk;

    test_stim_gen #(.STEP_BIT(2), .BUZ_BIT(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .div(div), .blink(blink), .start(start),
        .buzzer(buz_o[0]), .points(pts_o[0]), .les(les_o[0]), .pdata(pd_o[0]),
        .addr(ad0), .wea(wea_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    test_stim_gen #(.ADDR_W(5), .DEPTH(20), .STEP_BIT(2), .BUZ_BIT(3)) u_wrap (
        .clk(clk), .rst_n(rst_n), .sw(sw), .div(div), .blink(blink), .start(start),
        .buzzer(buz_o[1]), .points(pts_o[1]), .les(les_o[1]), .pdata(pd_o[1]),
        .addr(ad1), .wea(wea_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    test_stim_gen #(.DEPTH(40), .STEP_BIT(2), .BUZ_BIT(3)) u_long (
        .clk(clk), .rst_n(rst_n), .sw(sw), .div(div), .blink(blink), .start(start),
        .buzzer(buz_o[2]), .points(pts_o[2]), .les(les_o[2]), .pdata(pd_o[2]),
        .addr(ad2), .wea(wea_o[2]), .busy(busy_o[2]), .done(done_o[2]));

    function automatic logic [9:0] addr_of(input int k);
        case (k)
            0:       return ad0;
            1:       return {5'b0, ad1};
            default: return ad2;
        endcase
    endfunction

    function automatic logic [31:0] seed_m(input logic [15:0] s);
        case (s[6:5])
            2'b00:   return {s, s};
            2'b01:   return {16'h0, s};
            2'b10:   return 32'h1;
`ifdef TSG_LFSR_EN
            default: return {s, s} | 32'h1;
`else
            default: return 32'hFFFF_FFFF;
`endif
        endcase
    endfunction

    function automatic logic [31:0] next_m(input logic [1:0] m, input logic [31:0] p);
        case (m)
            2'b00:   return p;
            2'b01:   return p + 32'h1;
            2'b10:   return {p[30:0], p[31]};
`ifdef TSG_LFSR_EN
            default: return {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]};
`else
            default: return p;
`endif
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        div = div + 32'h1;
    endtask

    task automatic go_idle();
        sw = 16'h0;
        start = 1'b0;
        repeat (3) step();
    endtask

    // Starts a run on all three instances and scores every write against the pattern model.
    task automatic run_fill(input logic [15:0] swv);
        logic [9:0]  ea [3];
        logic [31:0] ep [3];
        logic        pw [3];
        logic [31:0] pdiv;
        int cyc;
        sw = swv;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_wr[k] = 0;
            pw[k] = 1'b0;
            ea[k] = swv[3] ? 10'h010 : 10'h000;
            ep[k] = seed_m(swv);
        end
        chk("busy_start", 64'(busy_o[0]), 64'd1);
        cyc = 0;
        while (cyc < 400 && !(n_wr[0] >= 16 && n_wr[1] >= 20 && n_wr[2] >= 40)) begin
            step();
            cyc++;
            pdiv = div - 32'h1;
            if (cyc == 20) chk("buzzer", 64'(buz_o[0]), 64'(swv[8] & pdiv[3]));
            for (int k = 0; k < 3; k++) begin
                if (wea_o[k]) begin
                    chk($sformatf("d%0d_gap", k), 64'(pw[k]), 64'd0);
                    chk($sformatf("d%0d_addr", k), 64'(addr_of(k)), 64'(ea[k]));
                    chk($sformatf("d%0d_pdata", k), 64'(pd_o[k]), 64'(ep[k]));
                    if (n_wr[k] < 40) pdlog[k][n_wr[k]] = pd_o[k];
                    last_ad[k] = addr_of(k);
                    n_wr[k]++;
                    ea[k] = (ea[k] + 10'h1) & ((k == 1) ? 10'h01F : 10'h3FF);
                    ep[k] = next_m(swv[6:5], ep[k]);
                end
                pw[k] = wea_o[k];
            end
        end
        repeat (12) begin
            step();
            for (int k = 0; k < 3; k++) if (wea_o[k]) n_wr[k]++;
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("d%0d_writes", k), 64'(n_wr[k]), 64'(DEP[k]));
    endtask

    initial begin
        int nw, cyc;
        logic wany;

        // Reset held while start toggles and div runs
        sw = 16'h00A8;
        blink = 8'h5A;
        wany = 1'b0;
        repeat (12) begin
            step();
            start = ~start;
            for (int k = 0; k < 3; k++) wany |= wea_o[k];
        end
        chk("rst_wea_seen", 64'(wany), 64'd0);
        chk("rst_points", pts_o[0], 64'd0);
        chk("rst_les", les_o[0], 64'd0);
        chk("rst_pdata", 64'(pd_o[0]), 64'd0);
        chk("rst_addr", 64'(ad0), 64'd0);
        chk("rst_busy_done_buz", 64'({busy_o[0], done_o[0], buz_o[0]}), 64'd0);
        start = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_les", les_o[0], 64'h5A5A_0000_0000_0000);
        chk("idle_busy_done", 64'({busy_o[0], done_o[0]}), 64'd0);

        // Incrementing fill, base page 1
        run_fill(16'h00A8);
        chk("incr_first_pd", 64'(pdlog[0][0]), 64'h0A8);
        chk("incr_last_pd", 64'(pdlog[0][15]), 64'h0B7);
        chk("incr_last_addr", 64'(last_ad[0]), 64'h01F);
        chk("incr_done_busy", 64'({done_o[0], busy_o[0]}), 64'b10);
        chk("incr_les_cnt", 64'(les_o[0][39:32]), 64'h10);
        chk("incr_points_hi", 64'(pts_o[0][63:32]), 64'h0B7);
        chk("incr_points_lo", 64'(pts_o[0][31:0]), 64'(div - 32'h1));
        chk("wrap_last_addr", 64'(last_ad[1]), 64'h003);
        chk("wrap_les_cnt", 64'(les_o[1][39:32]), 64'h14);
        chk("long_les_cnt", 64'(les_o[2][39:32]), 64'h28);
        go_idle();
        chk("done_to_idle", 64'(done_o[0]), 64'd0);

        // Walking one with buzzer enabled
        run_fill(16'h01C0);
        chk("walk_pd2", 64'(pdlog[0][2]), 64'h4);
        chk("walk_last_pd", 64'(pdlog[0][15]), 64'h8000);
        chk("walk_pd32", 64'(pdlog[2][31]), 64'h8000_0000);
        chk("walk_pd33", 64'(pdlog[2][32]), 64'h1);
        chk("walk_pd40", 64'(pdlog[2][39]), 64'h80);
        go_idle();

        // Constant pattern
        run_fill(16'h0088);
        chk("const_pd", 64'(pdlog[0][9]), 64'h0088_0088);
        go_idle();

        // Abort on the same cycle as a tick after 5 writes
        sw = 16'h00A8;
        start = 1'b1;
        step();
        start = 1'b0;
        nw = 0;
        cyc = 0;
        while (nw < 5 && cyc < 100) begin
            step();
            cyc++;
            if (wea_o[0]) nw++;
        end
        chk("abort_pre_writes", 64'(nw), 64'd5);
        cyc = 0;
        while (div[2:0] != 3'd4 && cyc < 16) begin
            step();
            cyc++;
        end
        sw = 16'h0028;
        nw = 0;
        repeat (12) begin
            step();
            if (wea_o[0]) nw++;
        end
        chk("abort_no_wea", 64'(nw), 64'd0);
        chk("abort_busy_done", 64'({busy_o[0], done_o[0]}), 64'd0);
        chk("abort_addr", 64'(ad0), 64'h015);
        chk("abort_pdata", 64'(pd_o[0]), 64'h0AD);
        chk("abort_cnt", 64'(les_o[0][39:32]), 64'h05);
        go_idle();

        // Asynchronous reset in the middle of a run
        sw = 16'h00A8;
        start = 1'b1;
        step();
        start = 1'b0;
        nw = 0;
        cyc = 0;
        while (nw < 2 && cyc < 100) begin
            step();
            cyc++;
            if (wea_o[0]) nw++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 64'({busy_o[0], done_o[0], wea_o[0]}), 64'd0);
        chk("midrst_addr_pd", {22'h0, ad0, pd_o[0]}, 64'd0);
        chk("midrst_points", pts_o[0], 64'd0);
        nw = 0;
        repeat (4) begin
            step();
            if (wea_o[0]) nw++;
        end
        chk("midrst_no_wea", 64'(nw), 64'd0);
        rst_n = 1'b1;
        go_idle();

        // Mode 11: LFSR when enabled, otherwise all-ones
        run_fill(16'h00E0);
`ifdef TSG_LFSR_EN
        chk("lfsr_pd0", 64'(pdlog[0][0]), 64'h00E0_00E1);
        chk("lfsr_pd1", 64'(pdlog[0][1]), 64'h01C0_01C2);
`else
        chk("ones_pd0", 64'(pdlog[0][0]), 64'hFFFF_FFFF);
        chk("ones_pd15", 64'(pdlog[0][15]), 64'hFFFF_FFFF);
`endif
        go_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
